serial_subtractor_controller: RTL and testbench

SERIAL_SUBTRACTOR_CONTROLLER -- requirements
Module: serial_subtractor_controller

---
 rtl/serial_sub_pkg.sv | 12 +
 rtl/serial_subtractor_controller_if.sv | 23 ++
 rtl/full_subtractor_cell.sv | 28 ++
 rtl/serial_subtractor_controller.sv | 129 ++++++++++++
 tb/tb_serial_subtractor_controller.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the serial subtractor: FSM state encoding and default width.
package serial_sub_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : serial_sub_pkg

// File: rtl/serial_subtractor_controller_if.sv
// Handshake/data bundle between a requester (master) and the serial subtractor (slave).
// Optional zero flag present only when SERIAL_SUB_ZERO_FLAG_EN is defined.
interface serial_subtractor_controller_if #(
    parameter int unsigned WIDTH = serial_sub_pkg::DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    logic             zero;

    modport master (output start, a, b, input busy, done, diff, borrow_out, zero);
    modport slave  (input start, a, b, output busy, done, diff, borrow_out, zero);
`else
    modport master (output start, a, b, input busy, done, diff, borrow_out);
    modport slave  (input start, a, b, output busy, done, diff, borrow_out);
`endif

endinterface : serial_subtractor_controller_if

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor (x - y - bin) built as a 1-to-8 demux with OR decoding.
module full_subtractor_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Minterm masks indexed by {x, y, bin}
    localparam logic [7:0] D_MINTERMS    = 8'b1001_0110; // 1, 2, 4, 7
    localparam logic [7:0] BOUT_MINTERMS = 8'b1000_1110; // 1, 2, 3, 7

    logic [2:0] sel;
    logic [7:0] line;

    assign sel = {x, y, bin};

    // Demux: route a constant 1 onto the output line selected by the input minterm
    always_comb begin
        line      = 8'b0;
        line[sel] = 1'b1;
    end

    assign d    = |(line & D_MINTERMS);
    assign bout = |(line & BOUT_MINTERMS);

endmodule : full_subtractor_cell

// File: rtl/serial_subtractor_controller.sv
// Bit-serial subtractor: computes a-b LSB first, one bit per cycle, through a single
// full-subtractor cell. Optional zero flag under SERIAL_SUB_ZERO_FLAG_EN.
module serial_subtractor_controller
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    serial_subtractor_controller_if.slave  bus
);

    localparam int unsigned    IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               brw_q, brw_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    logic               cell_d;
    logic               cell_bout;

    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   diff_q;
    logic               borrow_out_q;

    full_subtractor_cell u_cell (
        .x    (a_q[idx_q]),
        .y    (b_q[idx_q]),
        .bin  (brw_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            brw_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            brw_q   <= brw_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        brw_d   = brw_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    res_d   = '0;
                    brw_d   = 1'b0;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d[idx_q] = cell_d;
                brw_d        = cell_bout;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs; results only change on the RUN->DONE edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
        end else begin
            busy_q <= (state_d == RUN);
            done_q <= (state_d == DONE);
            if (state_q == RUN && state_d == DONE) begin
                diff_q       <= res_d;
                borrow_out_q <= brw_d;
            end
        end
    end

`ifdef SERIAL_SUB_ZERO_FLAG_EN
    logic zero_q;

    // Zero flag captured alongside the final result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
        end else if (state_q == RUN && state_d == DONE) begin
            zero_q <= (res_d == '0);
        end
    end

    assign bus.zero = zero_q;
`endif

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_out_q;

endmodule : serial_subtractor_controller

// File: tb/tb_serial_subtractor_controller.sv
// Self-checking bench for serial_subtractor_controller (WIDTH=8 and WIDTH=2 instances).
module tb_serial_subtractor_controller;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    serial_subtractor_controller_if #(.WIDTH(8)) bus8 ();
    serial_subtractor_controller_if #(.WIDTH(2)) bus2 ();

    serial_subtractor_controller #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    serial_subtractor_controller #(.WIDTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a-b modulo 2^w and unsigned borrow
    function automatic int unsigned ref_diff(input int unsigned x, input int unsigned y, input int unsigned w);
        int unsigned m;
        m = 32'd1 << w;
        return (x + m - y) % m;
    endfunction

    function automatic logic ref_borrow(input int unsigned x, input int unsigned y);
        return (x < y) ? 1'b1 : 1'b0;
    endfunction

    // Drive one operation on the chosen instance; returns edges from accept to done (-1 on timeout)
    task automatic run_op(input bit sel2, input logic [7:0] av, input logic [7:0] bv,
                          output int lat, output logic [7:0] d, output logic bo,
                          output logic z, output logic busy_seen, output logic done_after);
        if (sel2) begin bus2.start = 1'b1; bus2.a = av[1:0]; bus2.b = bv[1:0]; end
        else      begin bus8.start = 1'b1; bus8.a = av;      bus8.b = bv;      end
        @(posedge clk); #1;
        bus8.start = 1'b0; bus2.start = 1'b0;
        // Operands scrambled after acceptance must not matter
        bus8.a = 8'($urandom); bus8.b = 8'($urandom);
        bus2.a = 2'($urandom); bus2.b = 2'($urandom);
        busy_seen = sel2 ? bus2.busy : bus8.busy;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if ((sel2 ? bus2.done : bus8.done) === 1'b1) begin
                lat = i;
                break;
            end
        end
        d  = sel2 ? {6'b0, bus2.diff} : bus8.diff;
        bo = sel2 ? bus2.borrow_out : bus8.borrow_out;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
        z = sel2 ? bus2.zero : bus8.zero;
`else
        z = 1'b0;
`endif
        @(posedge clk); #1;
        done_after = sel2 ? bus2.done : bus8.done;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
        bus2.start = 1'b0; bus2.a = '0; bus2.b = '0;
        #23;
        checks++;
        if ({bus8.busy, bus8.done, bus8.diff, bus8.borrow_out} !== 11'd0) begin
            errors++;
            $display("FAIL reset8: busy=%b done=%b diff=%h borrow=%b, required all 0",
                     bus8.busy, bus8.done, bus8.diff, bus8.borrow_out);
        end
        checks++;
        if ({bus2.busy, bus2.done, bus2.diff, bus2.borrow_out} !== 5'd0) begin
            errors++;
            $display("FAIL reset2: busy=%b done=%b diff=%h borrow=%b, required all 0",
                     bus2.busy, bus2.done, bus2.diff, bus2.borrow_out);
        end
`ifdef SERIAL_SUB_ZERO_FLAG_EN
        checks++;
        if (bus8.zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_zero: zero=%b, required 0", bus8.zero);
        end
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // One WIDTH=8 operation checked against the reference
    task automatic check_op8(input string name, input logic [7:0] av, input logic [7:0] bv);
        int lat; logic [7:0] d; logic bo, z, bs, da;
        logic [7:0] ed; logic eb;
        ed = 8'(ref_diff(av, bv, 8));
        eb = ref_borrow(av, bv);
        run_op(1'b0, av, bv, lat, d, bo, z, bs, da);
        checks++;
        if (lat !== 8 || bs !== 1'b1 || da !== 1'b0) begin
            errors++;
            $display("FAIL %s timing: latency=%0d busy=%b done_next=%b, required 8/1/0", name, lat, bs, da);
        end
        checks++;
        if (d !== ed || bo !== eb) begin
            errors++;
            $display("FAIL %s result: %h-%h got diff=%h borrow=%b, required diff=%h borrow=%b",
                     name, av, bv, d, bo, ed, eb);
        end
`ifdef SERIAL_SUB_ZERO_FLAG_EN
        checks++;
        if (z !== (ed == 8'd0)) begin
            errors++;
            $display("FAIL %s zero: got %b, required %b", name, z, (ed == 8'd0));
        end
`endif
    endtask

    task automatic test_directed;
        check_op8("dir_5A_3C", 8'h5A, 8'h3C);
        check_op8("dir_00_01", 8'h00, 8'h01);
        check_op8("dir_A5_A5", 8'hA5, 8'hA5);
        check_op8("dir_FF_00", 8'hFF, 8'h00);
        check_op8("dir_00_FF", 8'h00, 8'hFF);
    endtask

    task automatic test_random;
        for (int i = 0; i < 24; i++) begin
            check_op8("random", 8'($urandom), 8'($urandom));
        end
    endtask

    // start held high: one result every WIDTH+2 cycles
    task automatic test_back_to_back;
        int t[$];
        logic [7:0] av, bv;
        av = 8'($urandom); bv = 8'($urandom);
        bus8.start = 1'b1; bus8.a = av; bus8.b = bv;
        for (int e = 1; e <= 35; e++) begin
            @(posedge clk); #1;
            if (bus8.done === 1'b1) begin
                t.push_back(e);
                checks++;
                if (bus8.diff !== 8'(ref_diff(av, bv, 8)) || bus8.borrow_out !== ref_borrow(av, bv)) begin
                    errors++;
                    $display("FAIL b2b result: diff=%h borrow=%b, required %h/%b",
                             bus8.diff, bus8.borrow_out, 8'(ref_diff(av, bv, 8)), ref_borrow(av, bv));
                end
            end
        end
        bus8.start = 1'b0;
        checks++;
        if (t.size() != 3 || t[0] != 9 || t[1] != 19 || t[2] != 29) begin
            errors++;
            $display("FAIL b2b timing: %0d done pulses (first at %0d), required 3 at 9,19,29",
                     t.size(), (t.size() > 0) ? t[0] : -1);
        end
        repeat (12) @(posedge clk);
        #1;
    endtask

    // start pulses while busy must not queue a second operation
    task automatic test_start_ignored;
        int n, first;
        n = 0; first = -1;
        bus8.start = 1'b1; bus8.a = 8'h33; bus8.b = 8'h44;
        for (int e = 1; e <= 22; e++) begin
            @(posedge clk); #1;
            if (bus8.done === 1'b1) begin
                n++;
                if (first < 0) first = e;
            end
            bus8.start = (e == 3 || e == 6 || e == 9) ? 1'b1 : 1'b0;
        end
        checks++;
        if (n != 1 || first != 9) begin
            errors++;
            $display("FAIL start_ignored: %0d done pulses first at %0d, required 1 at 9", n, first);
        end
        checks++;
        if (bus8.diff !== 8'hEF || bus8.borrow_out !== 1'b1) begin
            errors++;
            $display("FAIL start_ignored result: diff=%h borrow=%b, required EF/1", bus8.diff, bus8.borrow_out);
        end
    endtask

    // Reset mid-RUN aborts; next start after release works immediately
    task automatic test_reset_abort;
        int n;
        bus8.start = 1'b1; bus8.a = 8'hFF; bus8.b = 8'h00;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus8.diff !== 8'h00 || bus8.borrow_out !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset: busy=%b done=%b diff=%h borrow=%b, required 0/0/00/0",
                     bus8.busy, bus8.done, bus8.diff, bus8.borrow_out);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        n = 0;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk); #1;
            if (bus8.done === 1'b1 || bus8.busy === 1'b1) n++;
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL abort_no_done: %0d cycles with done/busy, required 0", n);
        end
        check_op8("abort_10_01", 8'h10, 8'h01);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_op8("first_after_reset", 8'($urandom), 8'($urandom));
    endtask

    // All 16 operand pairs on the WIDTH=2 instance
    task automatic test_width2;
        int lat; logic [7:0] d; logic bo, z, bs, da;
        for (int x = 0; x < 4; x++) begin
            for (int y = 0; y < 4; y++) begin
                run_op(1'b1, 8'(x), 8'(y), lat, d, bo, z, bs, da);
                checks++;
                if (lat !== 2 || d !== 8'(ref_diff(x, y, 2)) || bo !== ref_borrow(x, y)) begin
                    errors++;
                    $display("FAIL w2 %0d-%0d: latency=%0d diff=%0d borrow=%b, required 2/%0d/%b",
                             x, y, lat, d, bo, ref_diff(x, y, 2), ref_borrow(x, y));
                end
`ifdef SERIAL_SUB_ZERO_FLAG_EN
                checks++;
                if (z !== (ref_diff(x, y, 2) == 0)) begin
                    errors++;
                    $display("FAIL w2_zero %0d-%0d: got %b", x, y, z);
                end
`endif
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset;
        test_directed;
        test_random;
        test_back_to_back;
        test_start_ignored;
        test_reset_abort;
        test_width2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_serial_subtractor_controller
